// File: rtl/uart_tx_ctrl_if.sv
// Parallel-in request and serial-out status bundle for uart_tx_ctrl.
// The master drives the payload and request, and the slave drives the line and Busy.
interface uart_tx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit framer: start bit, LSB-first payload, optional parity, stop bit(s).
// Defining UART_TX_STOP2_EN stretches STOP to two bit times.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_ctrl_if.slave   bus
);

`ifdef UART_TX_STOP2_EN
  localparam int unsigned STOP_CYCLES = 2 * CLKS_PER_BIT;
`else
  localparam int unsigned STOP_CYCLES = CLKS_PER_BIT;
`endif
  localparam int unsigned TICK_W = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;
  localparam int unsigned IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q;
  logic [TICK_W-1:0]     tick_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  bit_done;
  logic                  stop_done;

  assign bit_done  = (tick_q == BIT_LAST);
  assign stop_done = (tick_q == STOP_LAST);

  // Outputs are loaded on the edge that enters each state, so TX_OUT and Busy line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tick_q <= '0;
          idx_q  <= '0;
          if (bus.Data_Valid) begin
            state_q   <= START;
            shreg_q   <= bus.P_DATA;
            par_en_q  <= bus.PAR_EN;
            // Parity is captured up front because the shift register is consumed during DATA.
            par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
            tick_q  <= '0;
            idx_q   <= '0;
            tx_q    <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            tick_q <= '0;
            if (idx_q == IDX_LAST) begin
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              tx_q    <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
            end
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        PARITY: begin
          if (bit_done) begin
            state_q <= STOP;
            tick_q  <= '0;
            tx_q    <= 1'b1;
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        STOP: begin
          if (stop_done) begin
            state_q <= IDLE;
            tick_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tick_q  <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboarded bench for uart_tx_ctrl: accepted requests queue a frame and a negedge monitor checks each Busy window.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
`ifdef UART_TX_STOP2_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  typedef struct {
    logic [7:0] d;
    bit         pe;
    bit         pt;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus  ();
  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus1 ();

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  frame_t exp_q[$];
  bit     cap[$];
  bit     in_frame = 1'b0;

  // Reference line level at cycle c of a frame, from the bit index that cycle falls in.
  function automatic bit exp_level(frame_t f, int cpb, int c);
    int b;
    b = c / cpb;
    if (b == 0) return 1'b0;
    if (b <= 8) return f.d[b-1];
    if (b == 9 && f.pe) return (($countones(f.d) % 2) == 1) ^ f.pt;
    return 1'b1;
  endfunction

  function automatic int frame_len(frame_t f, int cpb);
    return cpb * (1 + 8 + (f.pe ? 1 : 0) + STOP_BITS);
  endfunction

  task automatic check_frame();
    frame_t f;
    int     n;
    int     first_bad;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_frame: got a %0d-cycle frame, required none", cap.size());
      return;
    end
    f = exp_q.pop_front();
    n = frame_len(f, CPB);
    total++;
    if (cap.size() != n) begin
      bad++;
      $display("FAIL busy_len d=%h pe=%0d pt=%0d: got %0d required %0d", f.d, f.pe, f.pt, cap.size(), n);
    end
    first_bad = -1;
    for (int c = 0; c < n && c < cap.size(); c++)
      if (first_bad < 0 && cap[c] != exp_level(f, CPB, c)) first_bad = c;
    total++;
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL frame_bits d=%h pe=%0d pt=%0d cycle %0d: got %0d required %0d",
               f.d, f.pe, f.pt, first_bad, cap[first_bad], exp_level(f, CPB, first_bad));
    end
  endtask

  // Monitor: capture TX_OUT while Busy, score the frame when Busy drops.
  always @(negedge clk) begin
    if (rst) begin
      cap.delete();
      in_frame = 1'b0;
    end else if (bus.Busy === 1'b1) begin
      in_frame = 1'b1;
      cap.push_back(bus.TX_OUT);
    end else begin
      if (in_frame) begin
        in_frame = 1'b0;
        check_frame();
        cap.delete();
      end
      total++;
      if (bus.TX_OUT !== 1'b1) begin
        bad++;
        $display("FAIL idle_line: got %b required 1", bus.TX_OUT);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.Busy !== 1'b0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL idle_timeout: Busy still %b after %0d cycles, required 0", bus.Busy, n);
    end
  endtask

  // Issue one request from IDLE; optionally pulse a junk request mid-frame that must be ignored.
  task automatic send(input logic [7:0] d, input bit pe, input bit pt, input bit inject, input logic [7:0] junk);
    frame_t f;
    wait_idle();
    bus.P_DATA = d; bus.PAR_EN = pe; bus.PAR_TYP = pt; bus.Data_Valid = 1'b1;
    @(posedge clk); #1;
    f.d = d; f.pe = pe; f.pt = pt;
    exp_q.push_back(f);
    bus.Data_Valid = 1'b0;
    bus.P_DATA  = 8'($urandom);
    bus.PAR_EN  = 1'($urandom);
    bus.PAR_TYP = 1'($urandom);
    if (inject) begin
      repeat ($urandom_range(2, 30)) begin @(posedge clk); #1; end
      if (bus.Busy === 1'b1) begin
        bus.P_DATA = junk; bus.Data_Valid = 1'b1;
        @(posedge clk); #1;
        bus.Data_Valid = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f1;
    int     n1;
    int     errs;

    bus.P_DATA = '0;  bus.Data_Valid = 1'b0;  bus.PAR_EN = 1'b0;  bus.PAR_TYP = 1'b0;
    bus1.P_DATA = '0; bus1.Data_Valid = 1'b0; bus1.PAR_EN = 1'b0; bus1.PAR_TYP = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got tx=%b busy=%b required tx=1 busy=0", bus.TX_OUT, bus.Busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    send(8'hA5, 1'b1, 1'b0, 1'b0, 8'h00);
    send(8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
    send(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    send(8'hFF, 1'b0, 1'b0, 1'b0, 8'h00);
    send(8'h81, 1'b0, 1'b0, 1'b1, 8'h3C);

    // Abort a frame during data bit 3; the line must return high without a clock edge.
    send(8'hC3, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (17) @(posedge clk);
    #2;
    rst = 1'b1;
    void'(exp_q.pop_back());
    #1;
    total++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got tx=%b busy=%b required tx=1 busy=0", bus.TX_OUT, bus.Busy);
    end
    @(posedge clk); #1;
    total++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: got tx=%b busy=%b required tx=1 busy=0", bus.TX_OUT, bus.Busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    send(8'h96, 1'b1, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 30; i++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom));
      if ($urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end

    wait_idle();
    repeat (5) begin @(posedge clk); #1; end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_frames: got %0d unsent, required 0", exp_q.size());
    end

    // One-cycle bit time: every level must appear for exactly one cycle.
    bus1.P_DATA = 8'hA5; bus1.PAR_EN = 1'b1; bus1.PAR_TYP = 1'b1; bus1.Data_Valid = 1'b1;
    @(posedge clk); #1;
    bus1.Data_Valid = 1'b0;
    bus1.P_DATA = 8'h5A;
    f1.d = 8'hA5; f1.pe = 1'b1; f1.pt = 1'b1;
    n1 = frame_len(f1, 1);
    errs = 0;
    for (int c = 0; c < n1; c++) begin
      if (bus1.TX_OUT !== exp_level(f1, 1, c) || bus1.Busy !== 1'b1) errs++;
      @(posedge clk); #1;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL cpb1_bits: got %0d wrong cycles, required 0", errs);
    end
    total++;
    if (bus1.TX_OUT !== 1'b1 || bus1.Busy !== 1'b0) begin
      bad++;
      $display("FAIL cpb1_end: got tx=%b busy=%b required tx=1 busy=0", bus1.TX_OUT, bus1.Busy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the payload bits per frame.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4, giving the clock cycles each serial bit is held (legal range 1..255).
REQ-003 The block SHALL have port clk, input, width 1: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, width 1: reset, asynchronous and active-high.
REQ-005 The block SHALL have port P_DATA, input, width DATA_WIDTH: the parallel payload.
REQ-006 The block SHALL have port Data_Valid, input, width 1: a request to send P_DATA.
REQ-007 The block SHALL have port PAR_EN, input, width 1: when 1, a parity bit is appended.
REQ-008 The block SHALL have port PAR_TYP, input, width 1: 0 selects even parity, 1 selects odd parity.
REQ-009 The block SHALL have port TX_OUT, output, width 1: the serial line, idle high.
REQ-010 The block SHALL have port Busy, output, width 1: high while a frame is in progress.

Function
REQ-011 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-012 In IDLE with Data_Valid=1 at a clk edge, the block SHALL latch P_DATA, PAR_EN and PAR_TYP, and SHALL enter START on that edge.
REQ-013 The block SHALL ignore Data_Valid in every state except IDLE; inputs changing mid-frame SHALL NOT affect the frame.
REQ-014 TX_OUT SHALL be 1 in IDLE, 0 in START, data bit i in DATA (LSB first, i=0..DATA_WIDTH-1), the parity bit in PARITY, and 1 in STOP.
REQ-015 Each of START, each DATA bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a bit-tick counter.
REQ-016 After the last data bit, the FSM SHALL go to PARITY if the latched PAR_EN=1, and SHALL otherwise go directly to STOP.
REQ-017 The parity bit SHALL be computed from the latched data: XOR-reduce for even parity and the inverted XOR-reduce for odd parity; an all-zero payload SHALL give 0 for even parity and 1 for odd parity.
REQ-018 Busy SHALL be 1 in every state except IDLE; TX_OUT and Busy SHALL be registered outputs.
REQ-019 At the end of STOP, the FSM SHALL return to IDLE; a new frame SHALL be accepted no earlier than the first IDLE edge, so at least one idle cycle (TX_OUT=1) separates frames.
REQ-020 Frame length in cycles SHALL be CLKS_PER_BIT*(1+DATA_WIDTH+PAR_EN+STOP_BITS), where STOP_BITS is 1, or 2 under UART_TX_STOP2_EN.
REQ-021 With CLKS_PER_BIT=1, every bit SHALL be held exactly one cycle, with no skipped or repeated bits.

Reset
REQ-022 When rst=1, the block SHALL immediately (asynchronously) force the state to IDLE, TX_OUT=1, Busy=0, and clear the bit-tick counter, bit index and latched data/parity.
REQ-023 A reset asserted mid-frame SHALL abort the frame with no trailing bits; after rst deasserts, the first Data_Valid in IDLE SHALL start a clean frame.

Configuration
REQ-024 When macro UART_TX_STOP2_EN is defined, STOP SHALL last 2*CLKS_PER_BIT cycles (two stop bits).
REQ-025 When UART_TX_STOP2_EN is undefined, STOP SHALL last CLKS_PER_BIT cycles (one stop bit); there SHALL be no other behavioural difference.

Verification
REQ-026 Case: CLKS_PER_BIT=4, P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT holds each level 4 cycles as 0,1,0,1,0,0,1,0,1,0,1, and Busy=1 for 44 cycles.
REQ-027 Case: P_DATA=8'h00, PAR_EN=1, PAR_TYP=1 -> parity bit=1; the same payload with PAR_TYP=0 -> parity bit=0.
REQ-028 Case: PAR_EN=0, P_DATA=8'hFF, CLKS_PER_BIT=4 -> no PARITY state, frame 0,1x8,1, Busy=1 for 40 cycles.
REQ-029 Case: Data_Valid pulsed with P_DATA=8'h3C during DATA of a frame for 8'h81 -> the 8'h81 frame completes unchanged, and 8'h3C is never sent.
REQ-030 Case: rst asserted during bit 3 of DATA -> TX_OUT=1 and Busy=0 in the same cycle without waiting for clk; the next Data_Valid then sends a full, correct frame.
REQ-031 Case: UART_TX_STOP2_EN defined, 8'h5A, PAR_EN=0, CLKS_PER_BIT=4 -> STOP high for 8 cycles, Busy=1 for 44 cycles.
